// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: N-digit hex seven-segment controller.
// Loads are accepted through a valid/ready handshake into a pending buffer.
// The buffer is committed to the visible display on a refresh tick, so a
// half-updated display is never shown. The controller also provides
// leading-zero blanking, per-digit decimal points, per-digit blink and
// selectable segment polarity.
// Optional build macro SEG7_MUX_EN adds a registered multiplexed scan
// output (scan_seg / scan_an). Without it those ports are tied inactive.
module seg7_display_ctrl #(
  parameter int NUM_DIGITS  = 6,
  parameter int CLK_FREQ    = 10_000_000,
  parameter int REFRESH_HZ  = 1000,
  parameter int BLINK_TICKS = 250,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [4*NUM_DIGITS-1:0]   load_value,
  input  logic [NUM_DIGITS-1:0]     load_dp,
  input  logic [NUM_DIGITS-1:0]     load_blink,
  input  logic                      blank_lz,
  output logic                      commit_pulse,
  output logic [8*NUM_DIGITS-1:0]   seg_out,
  output logic [7:0]                scan_seg,
  output logic [NUM_DIGITS-1:0]     scan_an
);

  localparam int TICK_DIV = CLK_FREQ / REFRESH_HZ;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [7:0] SEG_UNLIT = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // Hex glyph with 1 = lit, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Map an internal lit-high byte onto the board polarity
  function automatic logic [7:0] apply_pol(input logic [7:0] lit);
    return (ACTIVE_LOW != 0) ? ~lit : lit;
  endfunction

  logic [TW-1:0]           tick_cnt;
  logic                    tick;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;
  state_t                  state, state_nxt;
  logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
  logic [NUM_DIGITS-1:0]   pend_dp, pend_blink, disp_dp, disp_blink;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zero_run;
  logic [7:0]              glyph;
  logic [8*NUM_DIGITS-1:0] seg_nxt;
  logic [8*NUM_DIGITS-1:0] seg_p1;

  assign tick = (tick_cnt == TICK_LAST);

  // Refresh tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Blink half-period counter, advanced by refresh ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Handshake FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Handshake FSM next state: HOLD means pending data awaits a tick
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_valid) state_nxt = HOLD;
      HOLD:    if (tick)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake FSM outputs
  always_comb begin
    load_ready   = (state == IDLE);
    commit_pulse = (state == HOLD) && tick;
  end

  // Pending buffer capture on an accepted load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blink <= '0;
    end else if (load_valid && load_ready) begin
      pend_val   <= load_value;
      pend_dp    <= load_dp;
      pend_blink <= load_blink;
    end
  end

  // Visible display registers, updated only on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val   <= '0;
      disp_dp    <= '0;
      disp_blink <= '0;
    end else if (commit_pulse) begin
      disp_val   <= pend_val;
      disp_dp    <= pend_dp;
      disp_blink <= pend_blink;
    end
  end

  // Leading-zero mask: scan from the top digit while nibbles stay zero
  always_comb begin
    lz_blank = '0;
    zero_run = blank_lz;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (disp_val[4*i +: 4] == 4'h0);
      if (i != 0) lz_blank[i] = zero_run;
    end
  end

  // Glyph assembly: LZ blanking keeps dp, blink blanks the whole digit
  always_comb begin
    seg_nxt = '0;
    glyph   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      glyph = {disp_dp[i], decode_hex(disp_val[4*i +: 4])};
      if (lz_blank[i])                 glyph[6:0] = '0;
      if (disp_blink[i] && blink_phase) glyph      = '0;
      seg_nxt[8*i +: 8] = apply_pol(glyph);
    end
  end

  // ---- stage p1: registered segment drive ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_p1 <= {NUM_DIGITS{SEG_UNLIT}};
    else        seg_p1 <= seg_nxt;
  end

  assign seg_out = seg_p1;

`ifdef SEG7_MUX_EN
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [IW-1:0]         scan_idx, scan_idx_nxt;
  logic                  scan_on, scan_on_nxt;
  logic [NUM_DIGITS-1:0] an_lit;

  // Scan index: first tick enables digit 0, later ticks advance and wrap
  always_comb begin
    scan_on_nxt  = scan_on | tick;
    scan_idx_nxt = scan_idx;
    if (tick && scan_on) scan_idx_nxt = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    an_lit = '0;
    an_lit[scan_idx_nxt] = 1'b1;
  end

  // Scan outputs registered from the same source as seg_out so they align
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx <= '0;
      scan_on  <= 1'b0;
      scan_an  <= AN_OFF;
      scan_seg <= SEG_UNLIT;
    end else begin
      scan_idx <= scan_idx_nxt;
      scan_on  <= scan_on_nxt;
      scan_an  <= scan_on_nxt ? ((ACTIVE_LOW != 0) ? ~an_lit : an_lit) : AN_OFF;
      scan_seg <= scan_on_nxt ? seg_nxt[int'(scan_idx_nxt)*8 +: 8] : SEG_UNLIT;
    end
  end
`else
  assign scan_an  = AN_OFF;
  assign scan_seg = SEG_UNLIT;
`endif

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Bench for seg7_display_ctrl: 6 digits, tick every 10 cycles, blink every
// 2 ticks, active-low. A transaction-level reference model tracks ticks,
// the pending buffer and the visible contents, and renders the expected
// segment bytes from a glyph table.
module tb_seg7_display_ctrl;
  localparam int ND = 6;
  localparam int TD = 10;
  localparam int BT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [23:0]   load_value = '0;
  logic [5:0]    load_dp = '0;
  logic [5:0]    load_blink = '0;
  logic          blank_lz = 1'b0;
  logic          commit_pulse;
  logic [47:0]   seg_out;
  logic [7:0]    scan_seg;
  logic [5:0]    scan_an;

  seg7_display_ctrl #(
    .NUM_DIGITS(ND), .CLK_FREQ(100), .REFRESH_HZ(10),
    .BLINK_TICKS(BT), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .load_dp(load_dp), .load_blink(load_blink),
    .blank_lz(blank_lz), .commit_pulse(commit_pulse), .seg_out(seg_out),
    .scan_seg(scan_seg), .scan_an(scan_an)
  );

  always #5 clk = ~clk;

  // Active-low glyphs, dp off
  logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_cyc, m_ticks;
  logic        m_pend;
  logic [23:0] p_val, d_val;
  logic [5:0]  p_dp, p_bl, d_dp, d_bl;
  logic [47:0] exp_seg;
  logic        last_tick, last_xfer;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] render(input logic [23:0] v, input logic [5:0] dp,
                                         input logic [5:0] bl, input logic phase,
                                         input logic lz);
    logic [47:0] r;
    logic [7:0]  b;
    int top_nz;
    top_nz = -1;
    for (int i = 0; i < ND; i++) if (v[4*i +: 4] != 4'h0) top_nz = i;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      if (bl[i] && phase) b = 8'hFF;
      else begin
        b = GLYPH[v[4*i +: 4]];
        if (lz && i > 0 && i > top_nz) b = 8'hFF;
        if (dp[i]) b[7] = 1'b0;
      end
      r[8*i +: 8] = b;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_ticks = 0; m_pend = 1'b0;
    d_val = '0; d_dp = '0; d_bl = '0;
    p_val = '0; p_dp = '0; p_bl = '0;
    exp_seg = {ND{8'hFF}};
    last_tick = 1'b0; last_xfer = 1'b0;
  endtask

  // One clock: check pre-edge outputs, advance the model, check post-edge
  task automatic step();
    logic        tick, xfer, commit;
    logic [47:0] nxt;
    logic [5:0]  exp_an;
    tick   = (m_cyc % TD) == TD - 1;
    chk("load_ready", load_ready, !m_pend);
    chk("commit_pulse", commit_pulse, tick && m_pend);
    xfer   = load_valid && !m_pend;
    commit = tick && m_pend;
    nxt    = render(d_val, d_dp, d_bl, ((m_ticks / BT) % 2) == 1, blank_lz);
    if (xfer) begin
      p_val = load_value; p_dp = load_dp; p_bl = load_blink;
    end
    @(posedge clk);
    #1;
    if (commit) begin
      d_val = p_val; d_dp = p_dp; d_bl = p_bl; m_pend = 1'b0;
    end else if (xfer) begin
      m_pend = 1'b1;
    end
    if (tick) m_ticks++;
    m_cyc++;
    exp_seg   = nxt;
    last_tick = tick;
    last_xfer = xfer;
    chk("seg_out", seg_out, exp_seg);
`ifdef SEG7_MUX_EN
    exp_an = (m_ticks == 0) ? 6'h3F : ~(6'b1 << ((m_ticks - 1) % ND));
    chk("scan_an", scan_an, exp_an);
    chk("scan_seg", scan_seg, (m_ticks == 0) ? 8'hFF : exp_seg[8*((m_ticks - 1) % ND) +: 8]);
`else
    exp_an = 6'h3F;
    chk("scan_an_tied", scan_an, exp_an);
    chk("scan_seg_tied", scan_seg, 8'hFF);
`endif
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!load_ready && n < 40) begin
      step();
      n++;
    end
    chk("ready_timeout", load_ready, 1'b1);
  endtask

  // Load a word, wait for commit, then one more cycle for the registered output
  task automatic do_load(input logic [23:0] v, input logic [5:0] dp, input logic [5:0] bl);
    wait_ready();
    load_value = v; load_dp = dp; load_blink = bl; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    wait_ready();
    step();
  endtask

  initial begin
    int   n, per_cnt;
    logic saw, counting;
    logic [7:0] d0;

    // Power-on reset
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg_out", seg_out, 48'hFFFF_FFFF_FFFF);
    chk("rst_load_ready", load_ready, 1'b1);
    chk("rst_commit", commit_pulse, 1'b0);
    rst_n = 1'b1;

    // Handshake and latency: load three cycles after a tick
    repeat (TD) step();
    n = 0;
    while ((m_cyc % TD) != 2 && n < 20) begin step(); n++; end
    load_value = 24'h12AB3F; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    n = 0; saw = 1'b0;
    while (!load_ready && n < 20) begin
      if (commit_pulse) saw = 1'b1;
      step();
      n++;
    end
    chk("hs_ready_low_cycles", n, 7);
    chk("hs_commit_seen", saw, 1'b1);
    step();
    chk("hs_glyphs", seg_out, 48'hF9A4_8883_B08E);

    // Leading-zero blanking
    blank_lz = 1'b1;
    do_load(24'h000405, 6'h00, 6'h00);
    chk("lz_405", seg_out, 48'hFFFF_FF99_C092);
    do_load(24'h000000, 6'h00, 6'h00);
    chk("lz_zero", seg_out, 48'hFFFF_FFFF_FFC0);
    blank_lz = 1'b0;
    step();
    chk("lz_off", seg_out, 48'hC0C0_C0C0_C0C0);

    // Blink with dp on digit 0
    do_load(24'h000008, 6'b000001, 6'b000001);
    d0 = seg_out[7:0];
    n = 0;
    while (seg_out[7:0] == d0 && n < 25) begin
      chk("blink_others", seg_out[47:8], 40'hC0C0_C0C0_C0);
      step(); n++;
    end
    chk("blink_first_change", n < 25, 1'b1);
    d0 = seg_out[7:0];
    chk("blink_level", (d0 == 8'h00) || (d0 == 8'hFF), 1'b1);
    n = 0;
    while (seg_out[7:0] == d0 && n < 25) begin
      chk("blink_others", seg_out[47:8], 40'hC0C0_C0C0_C0);
      step(); n++;
    end
    chk("blink_half_period", n, 20);

    // Back-pressure: valid held high, data changing every cycle
    per_cnt = 0; counting = 1'b0;
    load_valid = 1'b1;
    for (int c = 0; c < 150; c++) begin
      load_value = 24'($urandom);
      load_dp    = 6'($urandom);
      load_blink = 6'($urandom);
      blank_lz   = 1'($urandom);
      step();
      if (last_xfer) per_cnt++;
      if (last_tick) begin
        if (counting) chk("bp_xfer_per_tick", per_cnt, 1);
        per_cnt  = 0;
        counting = 1'b1;
      end
    end

    // Random valid pattern
    for (int c = 0; c < 150; c++) begin
      load_valid = 1'($urandom);
      load_value = 24'($urandom);
      load_dp    = 6'($urandom);
      load_blink = 6'($urandom);
      blank_lz   = 1'($urandom);
      step();
    end
    load_valid = 1'b0; blank_lz = 1'b0;

    // Asynchronous reset while data is pending
    wait_ready();
    load_value = 24'hABCDEF; load_dp = 6'h3F; load_blink = 6'h00; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    chk("mid_hold_pending", load_ready, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_seg_out", seg_out, 48'hFFFF_FFFF_FFFF);
    chk("arst_load_ready", load_ready, 1'b1);
    chk("arst_commit", commit_pulse, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (30) step();
    chk("post_reset_display", seg_out, 48'hC0C0_C0C0_C0C0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
